// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 mux.
// Grants are held until the owner drops req or the hold budget runs out.
module mux_sel_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int HL =
    (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HL);

  state_t           state;
  state_t           state_nx;
  logic [2:0]       last;
  logic [2:0]       last_nx;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [2:0]       sel_nx;
  logic [7:0]       grant_nx;
  logic             busy_nx;

  logic [2:0] start;
  logic [7:0] rot;
  logic [2:0] off;
  logic       found;
  logic [2:0] win;
  logic       timeout;
  logic       rel;
  logic       take;

  // The owner's own slot sits at the end of the rotation,
  // so on timeout it is only re-granted when nobody else asks.
  always_comb begin
    start = (state == GRANT) ? sel + 3'd1
                             : last + 3'd1;
    for (int i = 0; i < 8; i++) begin
      rot[i] = req[start + 3'(i)];
    end
  end

  always_comb begin
    off   = 3'd0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) begin
        off   = 3'(i);
        found = 1'b1;
      end
    end
    win = start + off;
  end

  always_comb begin
    timeout = (MAX_HOLD != 0) &&
              (hold_cnt == HOLD_LAST);
    rel     = !req[sel] || timeout;
    take    = en && found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 3'd7;
      hold_cnt <= '0;
      sel      <= 3'd0;
      grant    <= 8'd0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      hold_cnt <= cnt_nx;
      sel      <= sel_nx;
      grant    <= grant_nx;
      busy     <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (take) state_nx = GRANT;
      end
      GRANT: begin
        if (rel && !take) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sel_nx  = sel;
    last_nx = last;
    cnt_nx  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (take) begin
          sel_nx = win;
          cnt_nx = '0;
        end
      end
      GRANT: begin
        if (!rel) begin
          if (hold_cnt != '1) begin
            cnt_nx = hold_cnt + 1'b1;
          end
        end else begin
          last_nx = sel;
          cnt_nx  = '0;
          if (take) sel_nx = win;
        end
      end
      default: begin
        cnt_nx = '0;
      end
    endcase
  end

  always_comb begin
    busy_nx  = (state_nx == GRANT);
    grant_nx = busy_nx ? (8'd1 << sel_nx)
                       : 8'd0;
  end

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Scoreboard bench for mux_sel_rr_arbiter with a 4-cycle hold budget.
// A behavioural model predicts {busy,sel,grant} after every edge.
module tb_mux_sel_rr_arbiter;

  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;

  int errors;
  int checks;

  logic [11:0] sb_q[$];

  logic       m_busy;
  logic [2:0] m_sel;
  logic [2:0] m_last;
  int         m_cnt;

  mux_sel_rr_arbiter #(
    .MAX_HOLD(MH),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .req(req),
    .grant(grant),
    .sel(sel),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [11:0] act,
                     input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               tag, act, exp);
    end
  endtask

  function automatic logic [11:0] pack_m();
    logic [7:0] g;
    g = m_busy ? (8'd1 << m_sel) : 8'd0;
    return {m_busy, m_sel, g};
  endfunction

  function automatic int pick(input logic [7:0] r,
                              input logic [2:0] from);
    for (int k = 0; k < 8; k++) begin
      if (r[(int'(from) + 1 + k) % 8]) begin
        return (int'(from) + 1 + k) % 8;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 3'd0;
    m_last = 3'd7;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic [7:0] r,
                            input logic e);
    int  w;
    bit  rel;
    if (!m_busy) begin
      w = pick(r, m_last);
      if (e && w >= 0) begin
        m_busy = 1'b1;
        m_sel  = 3'(w);
        m_cnt  = 0;
      end
    end else begin
      rel = !r[m_sel] || (m_cnt == MH - 1);
      if (!rel) begin
        m_cnt++;
      end else begin
        m_last = m_sel;
        m_cnt  = 0;
        w = pick(r, m_sel);
        if (e && w >= 0) m_sel = 3'(w);
        else m_busy = 1'b0;
      end
    end
  endtask

  task automatic step(input string tag,
                      input logic [7:0] r,
                      input logic e);
    logic [11:0] exp;
    @(negedge clk);
    req = r;
    en  = e;
    model_step(r, e);
    sb_q.push_back(pack_m());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_empty"}, 12'h0, 12'hfff);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, {busy, sel, grant}, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    req    = 8'd0;
    model_reset();
    #12;
    chk("reset", {busy, sel, grant}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    step("t1_grant", 8'h01, 1'b1);
    chk("t1_abs", {busy, sel, grant}, 12'h801);
    step("t1_drop", 8'h00, 1'b1);
    chk("t1_idle", {busy, sel, grant}, 12'h000);

    for (int i = 0; i < 34; i++) begin
      step("t2_rot", 8'hff, 1'b1);
    end
    step("t2_end", 8'h00, 1'b1);

    for (int i = 0; i < 10; i++) begin
      step("t3_solo", 8'h20, 1'b1);
      chk("t3_busy", {11'd0, busy}, 12'h001);
    end
    step("t3_end", 8'h00, 1'b1);

    step("t4_own2", 8'h04, 1'b1);
    step("t4_hold", 8'h4c, 1'b1);
    step("t4_to3", 8'h48, 1'b1);
    chk("t4_sel3", {9'd0, sel}, 12'h003);
    step("t4_to6", 8'h40, 1'b1);
    chk("t4_sel6", {9'd0, sel}, 12'h006);
    step("t4_end", 8'h00, 1'b1);

    for (int i = 0; i < 3; i++) begin
      step("t5_blk", 8'h10, 1'b0);
    end
    step("t5_en", 8'h10, 1'b1);
    step("t5_keep", 8'h10, 1'b0);
    step("t5_keep", 8'h10, 1'b0);
    step("t5_idle", 8'h00, 1'b0);

    step("t6_g6", 8'h40, 1'b1);
    step("t6_h6", 8'h40, 1'b1);
    req   = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("t6_async", {busy, sel, grant}, 12'h000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("t6_first", 8'hc0, 1'b1);
    chk("t6_sel6", {9'd0, sel}, 12'h006);
    step("t6_end", 8'h00, 1'b1);

    for (int i = 0; i < 300; i++) begin
      step("rand",
           8'($urandom_range(0, 255)) &
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 7) != 0));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/mux_sel_rr_arbiter.md
Name: mux_sel_rr_arbiter

Overview:
Round-robin arbiter that shares one 8:1 bit-select mux among 8 requesters.
It drives the mux's 3-bit select and a one-hot grant, and holds each grant until the owner drops its request or a hold budget expires.
It sits directly in front of the 8:1 mux; `sel` connects to the mux select and `busy` qualifies the mux output.

Parameters:
MAX_HOLD, 16, max consecutive cycles per grant; 0 = unlimited.
CNT_W, 8, hold counter width; must satisfy MAX_HOLD < 2^CNT_W.

Ports:
clk    input   1  clock, rising edge
rst_n  input   1  reset, asynchronous, active-low
en     input   1  arbitration enable; 0 blocks new grants
req    input   8  request per requester; req[i] for mux input i
grant  output  8  one-hot registered grant; all-zero when idle
sel    output  3  registered mux select = index of granted requester
busy   output  1  registered; 1 while a grant is active (grant != 0)

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous and active-low.
- Reset state: grant=0, sel=0, busy=0, state=IDLE, hold_cnt=0, last=7 (first priority goes to requester 0).
- Priority: search req starting at index (last+1) mod 8, ascending with wrap; the first set bit wins. Implemented as a rotate + priority-encode, purely combinational.
- IDLE state:
  - If en=1 and req!=0, the winner is registered on the next edge: grant=1<<w, sel=w, busy=1, hold_cnt=0, state=GRANT.
  - Latency from req assertion to grant is 1 cycle.
  - If en=0 or req=0, stay IDLE; outputs are unchanged (sel holds its last value, grant=0, busy=0).
- GRANT state:
  - Each cycle, release is evaluated: release = !req[sel] OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD-1).
  - No release: hold_cnt++ and outputs hold. `en` does not affect an active grant.
  - Release: last=sel.
    - If en=1 and any req bit is set (excluding req[sel] when release was caused by its deassertion), the new winner is granted on the same edge, searched from (sel+1) mod 8. This gives back-to-back grants with no idle cycle; hold_cnt=0.
    - Otherwise: grant=0, busy=0, state=IDLE.
- Timeout re-grant: on timeout, the current owner is searched last. If it is the sole requester it is re-granted immediately with hold_cnt=0, so no starvation and no bubble.
- Grant duration:
  - A grant lasts exactly MAX_HOLD cycles when the request is held continuously.
  - With MAX_HOLD=1, grants rotate every cycle.
  - The counter never wraps.
- Request changes: changes on non-owner req bits during GRANT have no effect until release.
- Unlimited hold: with MAX_HOLD=0, release occurs only on request deassertion.
- Invariants: grant is always one-hot or zero; when busy=1, grant==(1<<sel).
- Reset mid-grant: asynchronously returns all state to reset values; no partial grant survives.
- Simultaneous release and new request on the same index: req is sampled as-is; an index whose req is high at release is eligible except under the owner-deassert rule above.

Test Plan:
1. Reset, then req=8'b0000_0001 -> one cycle later grant=0x01, sel=0, busy=1. Drop req -> next cycle grant=0, busy=0.
2. req=8'hFF held, MAX_HOLD=4 -> grants rotate 0,1,2,...,7,0. Each sel is held exactly 4 cycles, with no idle cycle between grants.
3. Only req[5] held, MAX_HOLD=4 -> sel=5 continuously. busy never drops; hold_cnt restarts every 4 cycles.
4. Owner is 2, req={3,6} set. Owner drops req[2] -> next grant sel=3. When 3 releases -> sel=6 (search starts at 4), not lower indices.
5. en=0 with req=0x10 -> stays idle, grant=0. Raise en -> grant=0x10 one cycle later. Lower en mid-grant -> grant persists until release, then IDLE.
6. Assert rst_n=0 mid-grant (sel=6) -> grant=0, busy=0, sel=0 immediately, without waiting for a clock. After release with req=0xC0 -> first grant sel=6 (last reset to 7).
